exp_align_shifter: RTL

//  Mantissa alignment stage of the half-precision add/sub datapath; directly downstream of the exponent subtractor.

---
 rtl/exp_align_shifter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/exp_align_shifter.sv
// Mantissa alignment for the half-precision add/sub path: picks the larger-exponent operand
// and serially right-shifts the smaller mantissa with guard/round/sticky collection.
module exp_align_shifter #(
    parameter int EXP_W  = 5,
    parameter int MANT_W = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EXP_W-1:0]    exp_a,
    input  logic [EXP_W-1:0]    exp_b,
    input  logic [EXP_W-1:0]    exp_diff,
    input  logic                exp_ge,
    input  logic                sign_a,
    input  logic                sign_b,
    input  logic [MANT_W-1:0]   mant_a,
    input  logic [MANT_W-1:0]   mant_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [EXP_W-1:0]    exp_out,
    output logic [MANT_W-1:0]   mant_big,
    output logic [MANT_W+2:0]   mant_small,
    output logic                sign_big,
    output logic                sign_small,
    output logic                swapped
);

    localparam int SM_W = MANT_W + 3;
    // Shifting by this much or more leaves only the sticky bit, so it is resolved in one step.
    localparam logic [EXP_W:0] SAT_SH = (EXP_W + 1)'(MANT_W + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [EXP_W-1:0]    cnt_q, cnt_d;
    logic [EXP_W-1:0]    exp_out_q, exp_out_d;
    logic [MANT_W-1:0]   mant_big_q, mant_big_d;
    logic [SM_W-1:0]     mant_small_q, mant_small_d;
    logic                sign_big_q, sign_big_d;
    logic                sign_small_q, sign_small_d;
    logic                swapped_q, swapped_d;

    logic                swap;
    logic [EXP_W-1:0]    mag;
    logic [MANT_W-1:0]   mant_lo;

    function automatic logic [SM_W-1:0] shift_step(input logic [SM_W-1:0] v);
        return {1'b0, v[SM_W-1:2], v[1] | v[0]};
    endfunction

    function automatic logic [SM_W-1:0] saturate(input logic [MANT_W-1:0] m);
        return {{(SM_W - 1){1'b0}}, |m};
    endfunction

    // Cout=0 means B is larger; the subtractor result is then negative and needs negating.
    assign swap    = ~exp_ge;
    assign mag     = exp_ge ? exp_diff : (~exp_diff + EXP_W'(1));
    assign mant_lo = swap ? mant_a : mant_b;

    assign in_ready   = rst_n && (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign exp_out    = exp_out_q;
    assign mant_big   = mant_big_q;
    assign mant_small = mant_small_q;
    assign sign_big   = sign_big_q;
    assign sign_small = sign_small_q;
    assign swapped    = swapped_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        exp_out_d    = exp_out_q;
        mant_big_d   = mant_big_q;
        mant_small_d = mant_small_q;
        sign_big_d   = sign_big_q;
        sign_small_d = sign_small_q;
        swapped_d    = swapped_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    swapped_d    = swap;
                    exp_out_d    = swap ? exp_b  : exp_a;
                    mant_big_d   = swap ? mant_b : mant_a;
                    sign_big_d   = swap ? sign_b : sign_a;
                    sign_small_d = swap ? sign_a : sign_b;
                    cnt_d        = '0;
                    if (mag == '0) begin
                        mant_small_d = {mant_lo, 3'b000};
                        state_d      = DONE;
                    end else if ({1'b0, mag} >= SAT_SH) begin
                        mant_small_d = saturate(mant_lo);
                        state_d      = DONE;
                    end else begin
                        mant_small_d = {mant_lo, 3'b000};
                        cnt_d        = mag;
                        state_d      = SHIFT;
                    end
                end
            end
            SHIFT: begin
                mant_small_d = shift_step(mant_small_q);
                cnt_d        = cnt_q - EXP_W'(1);
                if (cnt_q == EXP_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            exp_out_q    <= '0;
            mant_big_q   <= '0;
            mant_small_q <= '0;
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            swapped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            exp_out_q    <= exp_out_d;
            mant_big_q   <= mant_big_d;
            mant_small_q <= mant_small_d;
            sign_big_q   <= sign_big_d;
            sign_small_q <= sign_small_d;
            swapped_q    <= swapped_d;
        end
    end

endmodule
